proc_field_packer: RTL and testbench

- Parametrised successor to the fixed registered concatenation blocks.
- Accepts a stream of FIELD_W-bit fields over a valid/ready handshake and packs NUM_FIELDS of them into one registered word.
- Field order is selectable: first field at MSB or at LSB.
- Supports early flush of a partial word, output backpressure, and a wrapping count of emitted words. Sits between a narrow producer and a wide consumer.

---
 rtl/proc_packer_pkg.sv | 28 ++
 rtl/proc_field_insert.sv | 25 ++
 rtl/proc_field_packer.sv | 93 +++++++++
 tb/tb_proc_field_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_packer_pkg.sv
// Shared constants and helpers for the field packer.
// Slot offsets and count width live here so top and insert agree.
package proc_packer_pkg;

  localparam int FIELD_W_DEF    = 4;
  localparam int NUM_FIELDS_DEF = 4;
  localparam int MSB_FIRST_DEF  = 1;
  localparam int CNT_W_DEF      = 16;

  // Bit offset of slot idx inside the packed word.
  function automatic int slot_lsb(
    input int idx,
    input bit msb_first,
    input int fw,
    input int nf
  );
    if (msb_first)
      return (nf - 1 - idx) * fw;
    else
      return idx * fw;
  endfunction

  // Width needed to hold a field count of 1..nf.
  function automatic int count_w(input int nf);
    return $clog2(nf + 1);
  endfunction

endpackage

// File: rtl/proc_field_insert.sv
// Combinational slot writer: returns acc with field placed
// into the slot selected by idx.
module proc_field_insert
  import proc_packer_pkg::*;
#(
  parameter int FIELD_W    = FIELD_W_DEF,
  parameter int NUM_FIELDS = NUM_FIELDS_DEF,
  parameter int MSB_FIRST  = MSB_FIRST_DEF,
  localparam int WORD_W    = FIELD_W * NUM_FIELDS,
  localparam int IDX_W     = $clog2(NUM_FIELDS)
) (
  input  logic [WORD_W-1:0]  acc,
  input  logic [FIELD_W-1:0] field,
  input  logic [IDX_W-1:0]   idx,
  output logic [WORD_W-1:0]  word
);

  // Overwrite only the selected slot; other slots pass through.
  always_comb begin
    word = acc;
    word[slot_lsb(int'(idx), MSB_FIRST != 0,
                  FIELD_W, NUM_FIELDS) +: FIELD_W] = field;
  end

endmodule

// File: rtl/proc_field_packer.sv
// Packs a stream of narrow fields into registered wide words
// with flush, backpressure and a wrapping handoff counter.
module proc_field_packer
  import proc_packer_pkg::*;
#(
  parameter int FIELD_W    = FIELD_W_DEF,
  parameter int NUM_FIELDS = NUM_FIELDS_DEF,
  parameter int MSB_FIRST  = MSB_FIRST_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FIELD_W-1:0]                in_field,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [FIELD_W*NUM_FIELDS-1:0]     out_data,
  output logic [count_w(NUM_FIELDS)-1:0]    out_count,
  output logic [CNT_W-1:0]                  word_cnt
);

  localparam int WORD_W = FIELD_W * NUM_FIELDS;
  localparam int IDX_W  = $clog2(NUM_FIELDS);
  localparam int CW     = count_w(NUM_FIELDS);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] ins;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              complete;
  logic              handoff;
  logic              last_slot;

  proc_field_insert #(
    .FIELD_W    (FIELD_W),
    .NUM_FIELDS (NUM_FIELDS),
    .MSB_FIRST  (MSB_FIRST)
  ) u_insert (
    .acc   (acc),
    .field (in_field),
    .idx   (idx),
    .word  (ins)
  );

  // Handshake: a drained or empty output stage frees the input.
  always_comb begin
    in_ready  = rst_n && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    last_slot = (idx == IDX_W'(NUM_FIELDS - 1));
    complete  = accept && (in_last || last_slot);
    handoff   = out_valid && out_ready;
  end

  // Accumulator and fill index; a completed word restarts at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      idx <= '0;
    end else if (complete) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      acc <= ins;
      idx <= idx + IDX_W'(1);
    end
  end

  // Output register: reload on completion, drop valid on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= ins;
      out_count <= CW'(idx) + CW'(1);
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  // Count of words taken by the consumer, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_cnt <= '0;
    else if (handoff)
      word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_proc_field_packer.sv
// Bench for proc_field_packer: three instances (MSB-first,
// LSB-first, 4-bit counter) share one stimulus stream.
module tb_proc_field_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_field;
  logic        in_last;
  logic        out_ready;

  logic        rdy_m, rdy_l, rdy_w;
  logic        ov_m, ov_l, ov_w;
  logic [15:0] od_m, od_l, od_w;
  logic [2:0]  oc_m, oc_l, oc_w;
  logic [15:0] wc_m, wc_l;
  logic [3:0]  wc_w;

  proc_field_packer #(
    .FIELD_W(4), .NUM_FIELDS(4), .MSB_FIRST(1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_m),
    .in_field(in_field), .in_last(in_last),
    .out_valid(ov_m), .out_ready(out_ready),
    .out_data(od_m), .out_count(oc_m), .word_cnt(wc_m)
  );

  proc_field_packer #(
    .FIELD_W(4), .NUM_FIELDS(4), .MSB_FIRST(0), .CNT_W(16)
  ) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_l),
    .in_field(in_field), .in_last(in_last),
    .out_valid(ov_l), .out_ready(out_ready),
    .out_data(od_l), .out_count(oc_l), .word_cnt(wc_l)
  );

  proc_field_packer #(
    .FIELD_W(4), .NUM_FIELDS(4), .MSB_FIRST(1), .CNT_W(4)
  ) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy_w),
    .in_field(in_field), .in_last(in_last),
    .out_valid(ov_w), .out_ready(out_ready),
    .out_data(od_w), .out_count(oc_w), .word_cnt(wc_w)
  );

  typedef struct {
    logic [15:0] msb;
    logic [15:0] lsb;
    logic [2:0]  cnt;
  } exp_t;

  typedef struct {
    logic [15:0] fields;
    int          n;
    logic [15:0] e_msb;
    logic [15:0] e_lsb;
  } vec_t;

  exp_t q[$];
  int   tests;
  int   fails;
  int   hs;
  int   sent_words;
  bit   exp_vnext;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every handoff must match the oldest expected word.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (exp_vnext) begin
        chk("latency_valid", {31'b0, ov_m}, 1);
        chk("latency_valid_lsb", {31'b0, ov_l}, 1);
        exp_vnext = 0;
      end
      if (ov_m && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_word", {16'b0, od_m}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data_msb", {16'b0, od_m}, {16'b0, e.msb});
          chk("data_lsb", {16'b0, od_l}, {16'b0, e.lsb});
          chk("data_w", {16'b0, od_w}, {16'b0, e.msb});
          chk("count_msb", {29'b0, oc_m}, {29'b0, e.cnt});
          chk("count_lsb", {29'b0, oc_l}, {29'b0, e.cnt});
          chk("wcnt_before", {16'b0, wc_m}, hs & 32'hFFFF);
          chk("wcnt4_before", {28'b0, wc_w}, hs & 32'hF);
          hs++;
        end
      end
    end
  end

  task automatic send_field(input logic [3:0] f,
                            input logic last,
                            output bit ok);
    int  n;
    bit  a;
    n  = 0;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_field = f;
    in_last  = last;
    forever begin
      #4;
      a = rdy_m;
      @(posedge clk);
      if (a) begin
        ok = 1;
        break;
      end
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_field = 4'h0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] fields,
                           input int n,
                           input logic [15:0] e_msb,
                           input logic [15:0] e_lsb);
    bit   ok;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        e.msb = e_msb;
        e.lsb = e_lsb;
        e.cnt = 3'(n);
        q.push_back(e);
        sent_words++;
      end
      send_field(fields[15-4*i -: 4], i == n - 1, ok);
    end
    if (ok) exp_vnext = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ov"}, {29'b0, ov_m, ov_l, ov_w}, 0);
    chk({tag, "_od_m"}, {16'b0, od_m}, 0);
    chk({tag, "_od_l"}, {16'b0, od_l}, 0);
    chk({tag, "_oc"}, {23'b0, oc_m, oc_l, oc_w}, 0);
    chk({tag, "_wc_m"}, {16'b0, wc_m}, 0);
    chk({tag, "_wc_w"}, {28'b0, wc_w}, 0);
    chk({tag, "_rdy"}, {29'b0, rdy_m, rdy_l, rdy_w}, 0);
  endtask

  task automatic clear_model();
    q.delete();
    hs         = 0;
    sent_words = 0;
    exp_vnext  = 0;
  endtask

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    clear_model();
    tbl[0] = '{16'hABCD, 4, 16'hABCD, 16'hDCBA};
    tbl[1] = '{16'h1200, 2, 16'h1200, 16'h0021};
    tbl[2] = '{16'h5000, 1, 16'h5000, 16'h0005};
    tbl[3] = '{16'h1230, 3, 16'h1230, 16'h0321};
    tbl[4] = '{16'hF0F0, 4, 16'hF0F0, 16'h0F0F};
    tbl[5] = '{16'h3C7E, 4, 16'h3C7E, 16'hE7C3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_field  = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Table words back to back with the consumer always ready.
    for (int i = 0; i < 6; i++)
      send_word(tbl[i].fields, tbl[i].n, tbl[i].e_msb, tbl[i].e_lsb);
    idle(3);
    chk("table_drained", q.size(), 0);
    chk("table_wcnt", {16'b0, wc_m}, sent_words);

    // Backpressure: word held, input stalled, then released.
    @(negedge clk);
    out_ready = 1'b0;
    send_word(16'hABCD, 4, 16'hABCD, 16'hDCBA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk("bp_in_ready", {31'b0, rdy_m}, 0);
      chk("bp_hold_valid", {31'b0, ov_m}, 1);
      chk("bp_hold_data", {16'b0, od_m}, 32'hABCD);
    end
    fork
      send_word(16'h1234, 4, 16'h1234, 16'h4321);
      begin
        idle(2);
        out_ready = 1'b1;
      end
    join
    idle(3);
    chk("bp_drained", q.size(), 0);
    chk("bp_wcnt", {16'b0, wc_m}, sent_words);

    // Asynchronous reset in the middle of a partial word.
    begin
      bit ok;
      send_field(4'h9, 1'b0, ok);
      send_field(4'h8, 1'b0, ok);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    clear_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_word(16'h5678, 4, 16'h5678, 16'h8765);
    idle(3);
    chk("post_reset_drained", q.size(), 0);

    // Single-field words until the 4-bit counter wraps.
    for (int i = 0; i < 15; i++) begin
      logic [3:0] f;
      f = 4'(i + 1);
      send_word({f, 12'h000}, 1, {f, 12'h000}, {12'h000, f});
    end
    idle(3);
    chk("wrap_to_zero", {28'b0, wc_w}, 0);
    chk("wrap_sent", sent_words, 16);
    send_word(16'h7000, 1, 16'h7000, 16'h0007);
    idle(3);
    chk("wrap_to_one", {28'b0, wc_w}, 1);
    chk("wide_cnt", {16'b0, wc_m}, 17);
    chk("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
